// File: rtl/spdif_cs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spdif_cs_pkg
//  Description : Shared constants and state type for the S/PDIF channel-status
//                receive path.
//  Revision    : 1.0
// ============================================================================
package spdif_cs_pkg;

    localparam int          CS_BITS    = 192;
    localparam logic [7:0]  CS_LAST    = 8'(CS_BITS - 1);

    localparam int          CAT_LSB    = 8;
    localparam int          CAT_MSB    = 15;
    localparam logic [7:0]  CHNUM_LSB  = 8'd20;
    localparam logic [7:0]  CHNUM_MSB  = 8'd23;
    localparam int          FS_LSB     = 24;
    localparam int          FS_MSB     = 27;
    localparam int          WL_LSB     = 32;
    localparam int          WL_MSB     = 35;

    typedef enum logic [0:0] {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/spdif_cs_block_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : spdif_cs_block_assembler
//  Description : Collects channel-A status bits into a 192-bit word, enforces
//                A/B subframe ordering and cross-checks channel B against A.
//  Revision    : 1.0
// ============================================================================
module spdif_cs_block_assembler
    import spdif_cs_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                subframeValid,
    input  logic                subframeChan,
    input  logic                blockStart,
    input  logic                csBit,
    output logic [CS_BITS-1:0]  o_word,
    output logic [3:0]          o_chanNumB,
    output logic                o_mismatch,
    output logic                o_done,
    output logic                o_err
);

    state_t              r_state;
    logic [CS_BITS-1:0]  r_word;
    logic [7:0]          r_cnt;
    logic                r_expectB;
    logic                r_misPend;
    logic [3:0]          r_chanNumB;

    logic w_isA;
    logic w_isB;
    logic w_inChNum;
    logic w_bDiff;

    assign w_isA     = subframeValid && !subframeChan;
    assign w_isB     = subframeValid &&  subframeChan;
    assign w_inChNum = (r_cnt >= CHNUM_LSB) && (r_cnt <= CHNUM_MSB);
    assign w_bDiff   = w_isB && r_expectB && !w_inChNum && (csBit != r_word[r_cnt]);

    // A restart with blockStart is legal only at counter 0; wrap without it is not.
    assign o_err  = (r_state == COLLECT) &&
                    ((w_isA && (r_expectB ||
                                (blockStart && (r_cnt != 8'd0)) ||
                                (!blockStart && (r_cnt == 8'd0)))) ||
                     (w_isB && !r_expectB));
    assign o_done = (r_state == COLLECT) && w_isB && r_expectB && (r_cnt == CS_LAST);

    assign o_word     = r_word;
    assign o_chanNumB = r_chanNumB;
    assign o_mismatch = r_misPend || w_bDiff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= HUNT;
            r_word     <= '0;
            r_cnt      <= 8'd0;
            r_expectB  <= 1'b0;
            r_misPend  <= 1'b0;
            r_chanNumB <= 4'd0;
        end else begin
            case (r_state)
                HUNT: begin
                    if (w_isA && blockStart) begin
                        r_word[0] <= csBit;
                        r_cnt     <= 8'd0;
                        r_expectB <= 1'b1;
                        r_misPend <= 1'b0;
                        r_state   <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (w_isA) begin
                        if (r_expectB || (!blockStart && (r_cnt == 8'd0))) begin
                            r_state   <= HUNT;
                            r_cnt     <= 8'd0;
                            r_expectB <= 1'b0;
                        end else if (blockStart) begin
                            r_word[0] <= csBit;
                            r_cnt     <= 8'd0;
                            r_expectB <= 1'b1;
                            r_misPend <= 1'b0;
                        end else begin
                            r_word[r_cnt] <= csBit;
                            r_expectB     <= 1'b1;
                        end
                    end else if (w_isB) begin
                        if (!r_expectB) begin
                            r_state <= HUNT;
                            r_cnt   <= 8'd0;
                        end else begin
                            if (w_bDiff) begin
                                r_misPend <= 1'b1;
                            end
                            if (w_inChNum) begin
                                r_chanNumB[r_cnt[1:0]] <= csBit;
                            end
                            r_expectB <= 1'b0;
                            r_cnt     <= (r_cnt == CS_LAST) ? 8'd0 : r_cnt + 8'd1;
                        end
                    end
                end
                default: r_state <= HUNT;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/spdif_channel_status_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : spdif_channel_status_decoder
//  Description : Confirms channel-status blocks over consecutive repeats and
//                publishes the word with decoded consumer-mode fields.
//  Revision    : 1.0
// ============================================================================
module spdif_channel_status_decoder
    import spdif_cs_pkg::*;
#(
    parameter int CONFIRM_BLOCKS = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                subframeValid,
    input  logic                subframeChan,
    input  logic                blockStart,
    input  logic                csBit,
    output logic [CS_BITS-1:0]  csWord,
    output logic                csValid,
    output logic                csChanged,
    output logic                locked,
    output logic                isProfessional,
    output logic                isNonPcm,
    output logic                copyPermitted,
    output logic [7:0]          categoryCode,
    output logic [3:0]          channelNumA,
    output logic [3:0]          channelNumB,
    output logic [3:0]          samplingFreq,
    output logic [3:0]          wordLength,
    output logic                frameError,
    output logic                chanMismatch
);

    localparam logic [2:0] c_CONFIRM = 3'(CONFIRM_BLOCKS);

    logic [CS_BITS-1:0]  w_asmWord;
    logic [3:0]          w_asmChB;
    logic                w_asmMis;
    logic                w_done;
    logic                w_err;
    logic                w_same;
    logic [2:0]          w_confirmNext;

    logic [CS_BITS-1:0]  r_csWord;
    logic [CS_BITS-1:0]  r_prevWord;
    logic [2:0]          r_confirm;
    logic                r_published;
    logic                r_csValid;
    logic                r_csChanged;
    logic                r_locked;
    logic                r_frameError;
    logic                r_chanMismatch;
    logic [3:0]          r_chanNumB;

    spdif_cs_block_assembler u_asm (
        .clk           (clk),
        .rst_n         (rst_n),
        .subframeValid (subframeValid),
        .subframeChan  (subframeChan),
        .blockStart    (blockStart),
        .csBit         (csBit),
        .o_word        (w_asmWord),
        .o_chanNumB    (w_asmChB),
        .o_mismatch    (w_asmMis),
        .o_done        (w_done),
        .o_err         (w_err)
    );

    // A counter of 0 always restarts at 1, so no separate "previous valid" flag is needed.
    assign w_same        = (w_asmWord == r_prevWord);
    assign w_confirmNext = !w_same ? 3'd1 :
                           (r_confirm >= c_CONFIRM) ? c_CONFIRM : r_confirm + 3'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_csWord       <= '0;
            r_prevWord     <= '0;
            r_confirm      <= 3'd0;
            r_published    <= 1'b0;
            r_csValid      <= 1'b0;
            r_csChanged    <= 1'b0;
            r_locked       <= 1'b0;
            r_frameError   <= 1'b0;
            r_chanMismatch <= 1'b0;
            r_chanNumB     <= 4'd0;
        end else begin
            r_csValid    <= 1'b0;
            r_csChanged  <= 1'b0;
            r_frameError <= w_err;
            if (w_err) begin
                r_confirm <= 3'd0;
                r_locked  <= 1'b0;
            end else if (w_done) begin
                r_prevWord <= w_asmWord;
                r_confirm  <= w_confirmNext;
                if (!w_same) begin
                    r_locked <= 1'b0;
                end
                if (w_confirmNext == c_CONFIRM) begin
                    r_csWord       <= w_asmWord;
                    r_chanNumB     <= w_asmChB;
                    r_chanMismatch <= w_asmMis;
                    r_csValid      <= 1'b1;
                    r_csChanged    <= !r_published || (w_asmWord != r_csWord);
                    r_published    <= 1'b1;
                    r_locked       <= 1'b1;
                end
            end
        end
    end

    assign csWord         = r_csWord;
    assign csValid        = r_csValid;
    assign csChanged      = r_csChanged;
    assign locked         = r_locked;
    assign frameError     = r_frameError;
    assign chanMismatch   = r_chanMismatch;
    assign channelNumB    = r_chanNumB;
    assign isProfessional = r_csWord[0];
    assign isNonPcm       = r_csWord[1];
    assign copyPermitted  = r_csWord[2];
    assign categoryCode   = r_csWord[CAT_MSB:CAT_LSB];
    assign channelNumA    = r_csWord[CHNUM_MSB:CHNUM_LSB];
    assign samplingFreq   = r_csWord[FS_MSB:FS_LSB];
    assign wordLength     = r_csWord[WL_MSB:WL_LSB];

endmodule
`default_nettype wire

// File: tb/tb_spdif_channel_status_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spdif_channel_status_decoder
//  Description : Directed self-checking bench for the channel-status decoder.
//  Revision    : 1.0
// ============================================================================
module tb_spdif_channel_status_decoder;

    logic         clk;
    logic         rst_n;
    logic         subframeValid;
    logic         subframeChan;
    logic         blockStart;
    logic         csBit;
    logic [191:0] csWord;
    logic         csValid;
    logic         csChanged;
    logic         locked;
    logic         isProfessional;
    logic         isNonPcm;
    logic         copyPermitted;
    logic [7:0]   categoryCode;
    logic [3:0]   channelNumA;
    logic [3:0]   channelNumB;
    logic [3:0]   samplingFreq;
    logic [3:0]   wordLength;
    logic         frameError;
    logic         chanMismatch;

    int total = 0;
    int bad   = 0;

    logic [191:0] w1;
    logic [191:0] w2;

    spdif_channel_status_decoder #(.CONFIRM_BLOCKS(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .subframeValid  (subframeValid),
        .subframeChan   (subframeChan),
        .blockStart     (blockStart),
        .csBit          (csBit),
        .csWord         (csWord),
        .csValid        (csValid),
        .csChanged      (csChanged),
        .locked         (locked),
        .isProfessional (isProfessional),
        .isNonPcm       (isNonPcm),
        .copyPermitted  (copyPermitted),
        .categoryCode   (categoryCode),
        .channelNumA    (channelNumA),
        .channelNumB    (channelNumB),
        .samplingFreq   (samplingFreq),
        .wordLength     (wordLength),
        .frameError     (frameError),
        .chanMismatch   (chanMismatch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [191:0] mk(input logic [7:0] cat, input logic [3:0] fs,
                                        input logic [3:0] wl, input logic [3:0] cha);
        logic [191:0] w;
        w          = '0;
        w[2]       = 1'b1;
        w[15:8]    = cat;
        w[23:20]   = cha;
        w[27:24]   = fs;
        w[35:32]   = wl;
        return w;
    endfunction

    // One subframe valid for exactly one clock; returns 1 time unit after the capturing edge.
    task automatic sub(input logic ch, input logic bs, input logic b);
        @(negedge clk);
        subframeValid = 1'b1;
        subframeChan  = ch;
        blockStart    = bs;
        csBit         = b;
        @(posedge clk);
        #1;
        subframeValid = 1'b0;
        blockStart    = 1'b0;
    endtask

    task automatic frames(input logic [191:0] w, input logic [3:0] chb,
                          input int from, input int upto, input int flip);
        logic b;
        for (int i = from; i <= upto; i++) begin
            sub(1'b0, (i == 0), w[i]);
            b = w[i];
            if (i >= 20 && i <= 23) b = chb[i-20];
            if (i == flip) b = ~b;
            sub(1'b1, 1'b0, b);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        subframeValid = 1'b0;
        subframeChan  = 1'b0;
        blockStart    = 1'b0;
        csBit         = 1'b0;
        w1 = mk(8'h99, 4'd2, 4'd2, 4'd1);
        w2 = mk(8'h99, 4'd3, 4'd2, 4'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_csWord", csWord, 192'd0);
        chk("rst_csValid", {191'd0, csValid}, 192'd0);
        chk("rst_locked", {191'd0, locked}, 192'd0);
        chk("rst_frameError", {191'd0, frameError}, 192'd0);
        chk("rst_chanMismatch", {191'd0, chanMismatch}, 192'd0);
        chk("rst_chanNumB", {188'd0, channelNumB}, 192'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Hunting: subframes without blockStart are ignored silently
        sub(1'b0, 1'b0, 1'b1);
        sub(1'b1, 1'b0, 1'b0);
        chk("hunt_frameError", {191'd0, frameError}, 192'd0);
        chk("hunt_csValid", {191'd0, csValid}, 192'd0);

        // Two identical blocks confirm and publish
        frames(w1, 4'd2, 0, 191, -1);
        chk("blk1_csValid", {191'd0, csValid}, 192'd0);
        chk("blk1_locked", {191'd0, locked}, 192'd0);
        frames(w1, 4'd2, 0, 191, -1);
        chk("blk2_csValid", {191'd0, csValid}, 192'd1);
        chk("blk2_csChanged", {191'd0, csChanged}, 192'd1);
        chk("blk2_category", {184'd0, categoryCode}, 192'h99);
        chk("blk2_fs", {188'd0, samplingFreq}, 192'd2);
        chk("blk2_wl", {188'd0, wordLength}, 192'd2);
        chk("blk2_chA", {188'd0, channelNumA}, 192'd1);
        chk("blk2_chB", {188'd0, channelNumB}, 192'd2);
        chk("blk2_copy", {191'd0, copyPermitted}, 192'd1);
        chk("blk2_pro", {191'd0, isProfessional}, 192'd0);
        chk("blk2_mismatch", {191'd0, chanMismatch}, 192'd0);
        chk("blk2_locked", {191'd0, locked}, 192'd1);
        chk("blk2_csWord", csWord, w1);
        @(posedge clk);
        #1;
        chk("blk2_csValid_pulse", {191'd0, csValid}, 192'd0);

        // Locked republish, then a changed word needs re-confirmation
        frames(w1, 4'd2, 0, 191, -1);
        chk("blk3_csValid", {191'd0, csValid}, 192'd1);
        chk("blk3_csChanged", {191'd0, csChanged}, 192'd0);
        frames(w2, 4'd2, 0, 191, -1);
        chk("blk4_csValid", {191'd0, csValid}, 192'd0);
        chk("blk4_locked", {191'd0, locked}, 192'd0);
        chk("blk4_fs_held", {188'd0, samplingFreq}, 192'd2);
        frames(w2, 4'd2, 0, 191, -1);
        chk("blk5_csValid", {191'd0, csValid}, 192'd1);
        chk("blk5_csChanged", {191'd0, csChanged}, 192'd1);
        chk("blk5_fs", {188'd0, samplingFreq}, 192'd3);

        // blockStart at frame 100 restarts the block with a frameError
        frames(w2, 4'd2, 0, 99, -1);
        sub(1'b0, 1'b1, w2[0]);
        chk("bs100_frameError", {191'd0, frameError}, 192'd1);
        chk("bs100_locked", {191'd0, locked}, 192'd0);
        chk("bs100_csWord", csWord, w2);
        sub(1'b1, 1'b0, w2[0]);
        chk("bs100_errPulse", {191'd0, frameError}, 192'd0);
        frames(w2, 4'd2, 1, 191, -1);
        chk("bs100_blkA_csValid", {191'd0, csValid}, 192'd0);
        frames(w2, 4'd2, 0, 191, -1);
        chk("bs100_blkB_csValid", {191'd0, csValid}, 192'd1);
        chk("bs100_blkB_csChanged", {191'd0, csChanged}, 192'd0);
        chk("bs100_blkB_locked", {191'd0, locked}, 192'd1);

        // Missing blockStart after a complete block, then HUNT ignores a B subframe
        sub(1'b0, 1'b0, 1'b0);
        chk("nobs_frameError", {191'd0, frameError}, 192'd1);
        chk("nobs_locked", {191'd0, locked}, 192'd0);
        sub(1'b1, 1'b0, 1'b0);
        chk("nobs_hunt_B", {191'd0, frameError}, 192'd0);

        // Two B subframes in a row
        sub(1'b0, 1'b1, w2[0]);
        sub(1'b1, 1'b0, w2[0]);
        chk("bb_first_ok", {191'd0, frameError}, 192'd0);
        sub(1'b1, 1'b0, 1'b0);
        chk("bb_frameError", {191'd0, frameError}, 192'd1);

        // Channel B bit 8 differs from A
        frames(w2, 4'd2, 0, 191, 8);
        chk("mis_blk1_csValid", {191'd0, csValid}, 192'd0);
        frames(w2, 4'd2, 0, 191, 8);
        chk("mis_csValid", {191'd0, csValid}, 192'd1);
        chk("mis_chanMismatch", {191'd0, chanMismatch}, 192'd1);
        chk("mis_csWord", csWord, w2);

        // Asynchronous reset in the middle of a block
        frames(w1, 4'd2, 0, 191, -1);
        chk("rr_blk1_locked", {191'd0, locked}, 192'd0);
        frames(w1, 4'd2, 0, 49, -1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rr_csWord", csWord, 192'd0);
        chk("rr_category", {184'd0, categoryCode}, 192'd0);
        chk("rr_chanMismatch", {191'd0, chanMismatch}, 192'd0);
        chk("rr_chanNumB", {188'd0, channelNumB}, 192'd0);
        @(negedge clk);
        rst_n = 1'b1;
        frames(w1, 4'd2, 0, 191, -1);
        chk("rr_fresh1_csValid", {191'd0, csValid}, 192'd0);
        frames(w1, 4'd2, 0, 191, -1);
        chk("rr_fresh2_csValid", {191'd0, csValid}, 192'd1);
        chk("rr_fresh2_csChanged", {191'd0, csChanged}, 192'd1);
        chk("rr_fresh2_locked", {191'd0, locked}, 192'd1);
        chk("rr_fresh2_mismatch", {191'd0, chanMismatch}, 192'd0);
        chk("rr_fresh2_csWord", csWord, w1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
